// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int ARRAY_DIM_DEF   = 4;
  localparam int VECTOR_DIM_DEF  = 4;
  localparam int INPUT_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF  = 10;
  localparam int CW_DEF          = $clog2(ARRAY_DIM_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } sched_state_e;

  // Field order is the order the bus is packed in; a_base sits in the MSBs.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0]  a_base;
    logic [ADDR_WIDTH_DEF-1:0]  b_base;
    logic [ADDR_WIDTH_DEF-1:0]  o_base;
    logic [INPUT_WIDTH_DEF-1:0] stride;
    logic [CW_DEF-1:0]          rows;
    logic [CW_DEF-1:0]          cols;
  } tile_cmd_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile walker: produces the current tile command and the last-tile flag for one N x N product.
// Latency: the command is combinational from registers, updated one cycle after init/step.
// Backpressure: none; the command only moves on init/step, so it is stable while a tile is stalled.
//
// Ports: clk/rst; init (load a new N from init_n), step (advance column-fastest);
//        n (latched N), a_ptr/b_ptr/o_ptr (instruction base pointers);
//        cmd (tile command), last_tile (current tile is the final one of this N).
module tile_addr_gen
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM   = ARRAY_DIM_DEF,
  parameter int VECTOR_DIM  = VECTOR_DIM_DEF,
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int CW          = $clog2(ARRAY_DIM) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   step,
  input  logic [INPUT_WIDTH-1:0] init_n,
  input  logic [INPUT_WIDTH-1:0] n,
  input  logic [ADDR_WIDTH-1:0]  a_ptr,
  input  logic [ADDR_WIDTH-1:0]  b_ptr,
  input  logic [ADDR_WIDTH-1:0]  o_ptr,
  output tile_cmd_t              cmd,
  output logic                   last_tile
);

  localparam logic [INPUT_WIDTH-1:0] DIM_N  = INPUT_WIDTH'(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0]  DIM_A  = ADDR_WIDTH'(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0]  A_STEP = ADDR_WIDTH'(ARRAY_DIM * VECTOR_DIM);

  // r/c are kept as "remaining rows/cols" down-counters, which makes both the
  // min() clamp and the last-row/last-column test plain compares.
  logic [INPUT_WIDTH-1:0] rem_r, rem_c;
  logic [ADDR_WIDTH-1:0]  a_off;    // r * ARRAY_DIM * VECTOR_DIM
  logic [ADDR_WIDTH-1:0]  col_off;  // c * ARRAY_DIM
  logic [ADDR_WIDTH-1:0]  row_acc;  // r * ARRAY_DIM * N
  logic [ADDR_WIDTH-1:0]  row_step;

  // Constant multiplier only: ARRAY_DIM is a parameter.
  assign row_step = ADDR_WIDTH'(n) * DIM_A;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r   <= '0;
      rem_c   <= '0;
      a_off   <= '0;
      col_off <= '0;
      row_acc <= '0;
    end else if (init) begin
      rem_r   <= init_n;
      rem_c   <= init_n;
      a_off   <= '0;
      col_off <= '0;
      row_acc <= '0;
    end else if (step) begin
      if (rem_c > DIM_N) begin
        rem_c   <= rem_c - DIM_N;
        col_off <= col_off + DIM_A;
      end else begin
        rem_c   <= n;
        col_off <= '0;
        rem_r   <= rem_r - DIM_N;
        a_off   <= a_off + A_STEP;
        row_acc <= row_acc + row_step;
      end
    end
  end

  always_comb begin
    cmd        = '0;
    cmd.a_base = a_ptr + a_off;
    cmd.b_base = b_ptr + col_off;
    cmd.o_base = o_ptr + row_acc + col_off;
    cmd.stride = n;
    cmd.rows   = (rem_r >= DIM_N) ? CW'(ARRAY_DIM) : rem_r[CW-1:0];
    cmd.cols   = (rem_c >= DIM_N) ? CW'(ARRAY_DIM) : rem_c[CW-1:0];
  end

  assign last_tile = (rem_r <= DIM_N) && (rem_c <= DIM_N);

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Walks the instruction stream and issues one command per ARRAY_DIM x ARRAY_DIM output tile.
// Latency: start -> FETCH next cycle, first tile_valid 3 cycles after start; next tile 2 cycles after tile_done.
// Backpressure: tile_valid and all tile_* fields hold while tile_ready is low; one tile outstanding at most.
//
// Ports: clk/rst; ap_start/ap_done/busy control; inst_addr/inst_rd/inst_data instruction
//        memory (1-cycle read); tile_valid/tile_ready command handshake with tile_* fields;
//        tile_done completion pulse from the array.
module systolic_tile_scheduler
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM   = ARRAY_DIM_DEF,
  parameter int VECTOR_DIM  = VECTOR_DIM_DEF,
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int CW          = $clog2(ARRAY_DIM) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  inst_addr,
  output logic                   inst_rd,
  input  logic [INPUT_WIDTH-1:0] inst_data,
  output logic                   tile_valid,
  input  logic                   tile_ready,
  output logic [ADDR_WIDTH-1:0]  tile_a_base,
  output logic [ADDR_WIDTH-1:0]  tile_b_base,
  output logic [INPUT_WIDTH-1:0] tile_b_stride,
  output logic [ADDR_WIDTH-1:0]  tile_o_base,
  output logic [CW-1:0]          tile_rows,
  output logic [CW-1:0]          tile_cols,
  input  logic                   tile_done
);

  localparam logic [ADDR_WIDTH-1:0] VD_A = ADDR_WIDTH'(VECTOR_DIM);

  sched_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0]  inst_ptr, a_ptr, b_ptr, o_ptr;
  logic [ADDR_WIDTH-1:0]  nn;
  logic [INPUT_WIDTH-1:0] n;
  logic                   ag_init, ag_step, last_tile;
  tile_cmd_t              cmd;

  tile_addr_gen #(
    .ARRAY_DIM  (ARRAY_DIM),
    .VECTOR_DIM (VECTOR_DIM),
    .INPUT_WIDTH(INPUT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CW         (CW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (ag_init),
    .step     (ag_step),
    .init_n   (inst_data),
    .n        (n),
    .a_ptr    (a_ptr),
    .b_ptr    (b_ptr),
    .o_ptr    (o_ptr),
    .cmd      (cmd),
    .last_tile(last_tile)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // tile_done and ap_start are only looked at in WAIT and IDLE/DONE
  // respectively; anywhere else they fall through the default hold.
  always_comb begin
    state_nxt  = state;
    inst_rd    = 1'b0;
    tile_valid = 1'b0;
    ag_init    = 1'b0;
    ag_step    = 1'b0;
    case (state)
      IDLE, DONE: if (ap_start) state_nxt = FETCH;
      FETCH: begin
        inst_rd   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        ag_init   = 1'b1;
        state_nxt = (inst_data == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        tile_valid = 1'b1;
        if (tile_ready) state_nxt = WAIT;
      end
      WAIT: if (tile_done) state_nxt = NEXT;
      NEXT: begin
        ag_step   = !last_tile;
        state_nxt = last_tile ? FETCH : ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_ptr <= '0;
      a_ptr    <= '0;
      b_ptr    <= '0;
      o_ptr    <= '0;
      n        <= '0;
      nn       <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (ap_start) begin
          inst_ptr <= '0;
          a_ptr    <= '0;
          b_ptr    <= '0;
          o_ptr    <= '0;
        end
        DECODE: begin
          n  <= inst_data;
          // The only true multiply: done once per instruction, off the tile path.
          nn <= ADDR_WIDTH'(inst_data) * ADDR_WIDTH'(inst_data);
        end
        NEXT: if (last_tile) begin
          a_ptr    <= a_ptr + ADDR_WIDTH'(n) * VD_A;
          b_ptr    <= b_ptr + ADDR_WIDTH'(n) * VD_A;
          o_ptr    <= o_ptr + nn;
          inst_ptr <= inst_ptr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign ap_done       = (state == DONE);
  assign busy          = (state != IDLE) && (state != DONE);
  assign inst_addr     = inst_ptr;
  assign tile_a_base   = cmd.a_base;
  assign tile_b_base   = cmd.b_base;
  assign tile_o_base   = cmd.o_base;
  assign tile_b_stride = cmd.stride;
  assign tile_rows     = cmd.rows;
  assign tile_cols     = cmd.cols;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: directed instruction streams, scoreboard on accepted tiles.
// Latency: n/a.
// Backpressure: drives tile_ready low for selected tiles.
module tb_systolic_tile_scheduler;
  import systolic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ap_start = 1'b0;
  logic       tile_ready = 1'b1;
  logic       tile_done = 1'b0;
  logic       ap_done, busy, inst_rd, tile_valid;
  logic [9:0] inst_addr, tile_a_base, tile_b_base, tile_o_base;
  logic [7:0] inst_data = 8'd0;
  logic [7:0] tile_b_stride;
  logic [2:0] tile_rows, tile_cols;
  logic [7:0] mem [0:15];

  int checks = 0;
  int failures = 0;
  tile_cmd_t exp_q[$];
  tile_cmd_t cur, held_cmd;
  logic held;

  systolic_tile_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .busy         (busy),
    .inst_addr    (inst_addr),
    .inst_rd      (inst_rd),
    .inst_data    (inst_data),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_a_base  (tile_a_base),
    .tile_b_base  (tile_b_base),
    .tile_b_stride(tile_b_stride),
    .tile_o_base  (tile_o_base),
    .tile_rows    (tile_rows),
    .tile_cols    (tile_cols),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) if (inst_rd) inst_data <= mem[inst_addr[3:0]];

  assign cur = {tile_a_base, tile_b_base, tile_o_base, tile_b_stride, tile_rows, tile_cols};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_tile(input int a, input int b, input int o, input int s, input int r, input int c);
    tile_cmd_t t;
    t.a_base = 10'(a);
    t.b_base = 10'(b);
    t.o_base = 10'(o);
    t.stride = 8'(s);
    t.rows   = 3'(r);
    t.cols   = 3'(c);
    exp_q.push_back(t);
  endtask

  // Monitor: compares every accepted tile against the scoreboard and checks
  // that stalled commands stay put.
  initial begin
    held = 1'b0;
    held_cmd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(tile_valid), 64'd1);
          chk("hold_fields", 64'(cur), 64'(held_cmd));
        end
        if (tile_valid && tile_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tile: got 0x%0h required no tile", cur);
          end else begin
            chk("tile_cmd", 64'(cur), 64'(exp_q.pop_front()));
          end
        end
        held = tile_valid && !tile_ready;
        held_cmd = cur;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk("start_fetch", {ap_done, busy, inst_rd, inst_addr}, {1'b0, 1'b1, 1'b1, 10'd0});
  endtask

  // Waits for a tile (bounded), optionally stalls it, accepts it, then pulses
  // tile_done 10 cycles after acceptance.
  task automatic serve_tile(input int exp_wait, input int hold, input bit stray);
    int t = 0;
    if (hold > 0) tile_ready = 1'b0;
    while (!tile_valid && t < 50) begin
      tick();
      t++;
    end
    chk("valid_latency", 64'(t), 64'(exp_wait));
    if (!tile_valid) return;
    for (int i = 0; i < hold; i++) begin
      tile_done = stray && (i == 0);
      tick();
    end
    tile_done  = 1'b0;
    tile_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (stray) ap_start = (i == 3);
      tick();
      if (stray && i == 3)
        chk("start_ignored", {busy, inst_rd, tile_valid, ap_done}, 4'b1000);
    end
    ap_start  = 1'b0;
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
  endtask

  // Called just after the last tile's done edge: NEXT, FETCH, DECODE, then DONE.
  task automatic finish_stream(input int fetch_addr);
    chk("gap_next", {ap_done, inst_rd, tile_valid}, 3'b000);
    tick();
    chk("gap_fetch", {inst_rd, inst_addr}, {1'b1, 10'(fetch_addr)});
    tick();
    chk("gap_decode", {ap_done, tile_valid}, 2'b00);
    tick();
    chk("done_level", {ap_done, busy, tile_valid}, 3'b100);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ap_done, busy, inst_rd, tile_valid, inst_addr, tile_a_base,
                tile_b_base, tile_o_base, tile_b_stride, tile_rows, tile_cols});
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();

    // Single full tile: [4,0]
    mem[0] = 8'd4; mem[1] = 8'd0;
    push_tile(0, 0, 0, 4, 4, 4);
    do_start();
    serve_tile(2, 0, 1'b0);
    finish_stream(1);

    // Partial tiles [6,0]; second tile stalled 5 cycles with stray inputs
    mem[0] = 8'd6; mem[1] = 8'd0;
    push_tile(0, 0, 0, 6, 4, 4);
    push_tile(0, 4, 4, 6, 4, 2);
    push_tile(16, 0, 24, 6, 2, 4);
    push_tile(16, 4, 28, 6, 2, 2);
    do_start();
    serve_tile(2, 0, 1'b0);
    serve_tile(1, 5, 1'b1);
    serve_tile(1, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    finish_stream(1);

    // Multi-instruction [4,6,0]
    mem[0] = 8'd4; mem[1] = 8'd6; mem[2] = 8'd0;
    push_tile(0, 0, 0, 4, 4, 4);
    push_tile(16, 16, 16, 6, 4, 4);
    push_tile(16, 20, 20, 6, 4, 2);
    push_tile(32, 16, 40, 6, 2, 4);
    push_tile(32, 20, 44, 6, 2, 2);
    do_start();
    serve_tile(2, 0, 1'b0);
    serve_tile(3, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    finish_stream(2);

    // Empty stream [0], then restart from DONE
    mem[0] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      do_start();
      tick();
      chk("empty_decode", {ap_done, tile_valid}, 2'b00);
      tick();
      chk("empty_done", {ap_done, busy, tile_valid}, 3'b100);
    end

    // Reset mid-run in WAIT of tile 2 of [6,0], then a fresh run
    mem[0] = 8'd6; mem[1] = 8'd0;
    push_tile(0, 0, 0, 6, 4, 4);
    push_tile(0, 4, 4, 6, 4, 2);
    push_tile(16, 0, 24, 6, 2, 4);
    push_tile(16, 4, 28, 6, 2, 2);
    do_start();
    serve_tile(2, 0, 1'b0);
    begin
      int t = 0;
      while (!tile_valid && t < 50) begin
        tick();
        t++;
      end
      chk("rst_tile2_latency", 64'(t), 64'd1);
    end
    tick();
    chk("rst_in_wait", {busy, tile_valid}, 2'b10);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    chk("queue_before_reset", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", all_outs(), 64'd0);
    push_tile(0, 0, 0, 6, 4, 4);
    push_tile(0, 4, 4, 6, 4, 2);
    push_tile(16, 0, 24, 6, 2, 4);
    push_tile(16, 4, 28, 6, 2, 2);
    do_start();
    serve_tile(2, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    serve_tile(1, 0, 1'b0);
    finish_stream(1);

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
